seq_mult8x8_ctrl: RTL and testbench
===================================

Name: seq_mult8x8_ctrl

Overview:
Sequential controller for the 8x8 multiplier. It latches two 8-bit operands and steps a shared combinational 4x4 multiplier through the four nibble cross-products. It shifts each 8-bit partial product into place and accumulates it, returning a 16-bit product with a start/done handshake. It sits directly upstream and downstream of the 4x4 multiplier: it drives that multiplier's inputs and consumes its product.

Parameters:
REG_PP, 0, 1 = register mult_p before accumulation, adding one cycle of latency; 0 = accumulate mult_p in the same cycle it is driven.

Ports:
clk  input  1  single clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a multiply; sampled only in IDLE
dataa  input  8  multiplicand; captured on accepted start
datab  input  8  multiplier; captured on accepted start
mult_a  output  4  nibble of the latched dataa, to the 4x4 multiplier's dataa
mult_b  output  4  nibble of the latched datab, to the 4x4 multiplier's datab
mult_p  input  8  product returned by the 4x4 multiplier (unsigned, combinational)
product  output  16  result register; holds the last completed result
done  output  1  one-cycle pulse; product is updated in the same cycle
busy  output  1  high in CALC and DONE

Behaviour:
- Reset values: state=IDLE, product=0, done=0, busy=0, mult_a=0, mult_b=0, accumulator=0, step count=0, operand registers=0.
- Reset has priority over all other inputs in every state and aborts any operation in flight. product clears to 0 and no done pulse is produced.
- States: IDLE, CALC, DONE.
- IDLE, start=1 at edge: latch dataa/datab, clear the accumulator, set count=0, go to CALC.
- IDLE, start=0: stay in IDLE.
- CALC steps, k = count 0..3, with mult_a/mult_b driven combinationally from the operand registers:
  - k0: a[3:0] x b[3:0], shift 0
  - k1: a[7:4] x b[3:0], shift 4
  - k2: a[3:0] x b[7:4], shift 4
  - k3: a[7:4] x b[7:4], shift 8
- Accumulation:
  - REG_PP=0: at each CALC edge, acc <= acc + (mult_p zero-extended to 16 bits << shift(k)); count increments.
  - REG_PP=1: mult_p is registered with its shift tag; accumulation lags one cycle; CALC lasts 5 cycles (the last cycle only accumulates). mult_a/mult_b drive 0 in that last cycle.
- Leaving CALC: on the edge that performs the final accumulation, product <= final sum and state goes to DONE.
- DONE lasts exactly one cycle with done=1, then returns to IDLE.
- Width: 16-bit unsigned arithmetic with no overflow possible (max 0xFF x 0xFF = 0xFE01). No signed support.
- Latency: start high in cycle t gives done=1 in cycle t+5 (REG_PP=0) or t+6 (REG_PP=1).
- start while busy (CALC or DONE) is ignored and does not disturb the operation in flight. A new start is accepted in the first IDLE cycle after DONE, so the back-to-back period is 6 cycles (REG_PP=0).
- dataa/datab changes after the accepted start do not affect the result.
- product holds its previous value through CALC and changes only when entering DONE.
- mult_a/mult_b are 0 in IDLE and DONE.

Test Plan:
- REG_PP=0, dataa=0xA5, datab=0x3C, start for 1 cycle -> (mult_a,mult_b) sequence (5,C),(A,C),(5,3),(A,3) in cycles t+1..t+4; done=1 in cycle t+5 only; product=0x26AC held afterwards.
- Corner operands: 0xFF x 0xFF -> product=0xFE01; 0x00 x 0x7E -> 0x0000; 0x01 x 0x80 -> 0x0080; 0x12 x 0x34 -> 0x03A8.
- Start 0x12 x 0x34; pulse start with 0xFF/0xFF at t+2 and change dataa/datab -> still exactly one done, at t+5, with product=0x03A8; no second operation begins.
- Reset asserted at t+3 mid-CALC -> next cycle state=IDLE, product=0, busy=0; no done pulse; a fresh 0x03 x 0x05 then yields 0x000F.
- Back-to-back: start held high continuously with 0x10 x 0x10, then 0x20 x 0x02 -> done at t+5 with 0x0100 and at t+11 with 0x0040; product holds 0x0100 until t+11.
- REG_PP=1, 0xA5 x 0x3C -> done at t+6, product=0x26AC; random sweep of 1000 operand pairs matches dataa*datab for both REG_PP values.

Source files
------------

// File: rtl/seq_mult8x8_ctrl.sv
// seq_mult8x8_ctrl: 8x8 unsigned multiply by stepping a shared 4x4 multiplier over the four nibble cross-products.
module seq_mult8x8_ctrl #(
  parameter int REG_PP = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  dataa,
  input  logic [7:0]  datab,
  output logic [3:0]  mult_a,
  output logic [3:0]  mult_b,
  input  logic [7:0]  mult_p,
  output logic [15:0] product,
  output logic        done,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_next;
  logic [7:0] a_q, b_q, pp_q;
  logic [15:0] acc, addend, sum;
  logic [2:0] count;
  logic [3:0] shift, tag_q;
  logic step_mul, last;
  always_comb begin
    step_mul = state == CALC && !count[2];
    shift = count == 3'd0 ? 4'd0 : count == 3'd3 ? 4'd8 : 4'd4;
    mult_a = step_mul ? (count[0] ? a_q[7:4] : a_q[3:0]) : 4'd0;
    mult_b = step_mul ? (count[1] ? b_q[7:4] : b_q[3:0]) : 4'd0;
    // with REG_PP the product of the previous step is added, tagged with its own shift
    addend = REG_PP != 0 ? ({8'd0, pp_q} << tag_q) : ({8'd0, mult_p} << shift);
    sum = acc + addend;
    last = count == (REG_PP != 0 ? 3'd4 : 3'd3);
    state_next = state == IDLE ? (start ? CALC : IDLE) : state == CALC ? (last ? DONE : CALC) : IDLE;
    done = state == DONE;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      count <= '0;
      pp_q <= '0;
      tag_q <= '0;
      product <= '0;
    end else if (state == IDLE && start) begin
      a_q <= dataa;
      b_q <= datab;
      acc <= '0;
      count <= '0;
      pp_q <= '0;
      tag_q <= '0;
    end else if (state == CALC) begin
      acc <= sum;
      count <= count + 3'd1;
      pp_q <= mult_p;
      tag_q <= shift;
      if (last) product <= sum;
    end
  end
endmodule

// File: tb/tb_seq_mult8x8_ctrl.sv
// tb_seq_mult8x8_ctrl: directed and random checks of both REG_PP variants sharing one stimulus.
module tb_seq_mult8x8_ctrl;
  logic clk = 1'b0;
  logic reset, start;
  logic [7:0] dataa, datab;
  logic [3:0] mult_a0, mult_b0, mult_a1, mult_b1;
  logic [7:0] mult_p0, mult_p1;
  logic [15:0] product0, product1;
  logic done0, done1, busy0, busy1;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  assign mult_p0 = mult_a0 * mult_b0;
  assign mult_p1 = mult_a1 * mult_b1;

  seq_mult8x8_ctrl #(.REG_PP(0)) dut0 (.clk(clk), .reset(reset), .start(start), .dataa(dataa), .datab(datab),
    .mult_a(mult_a0), .mult_b(mult_b0), .mult_p(mult_p0), .product(product0), .done(done0), .busy(busy0));
  seq_mult8x8_ctrl #(.REG_PP(1)) dut1 (.clk(clk), .reset(reset), .start(start), .dataa(dataa), .datab(datab),
    .mult_a(mult_a1), .mult_b(mult_b1), .mult_p(mult_p1), .product(product1), .done(done1), .busy(busy1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b, output int lat0, output int lat1,
                    output logic [15:0] p0, output logic [15:0] p1);
    lat0 = -1;
    lat1 = -1;
    p0 = 'x;
    p1 = 'x;
    start = 1'b1;
    dataa = a;
    datab = b;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (done0 && lat0 < 0) begin lat0 = c; p0 = product0; end
      if (done1 && lat1 < 0) begin lat1 = c; p1 = product1; end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    dataa = 8'h55;
    datab = 8'h66;
    tick();
    tick();
    reset = 1'b0;
    start = 1'b0;
    tests++;
    if ({product0, done0, busy0, mult_a0, mult_b0} !== 26'd0) begin
      fails++;
      $display("FAIL reset0 got p=%h d=%b b=%b a=%h b=%h want all 0", product0, done0, busy0, mult_a0, mult_b0);
    end
    tests++;
    if ({product1, done1, busy1, mult_a1, mult_b1} !== 26'd0) begin
      fails++;
      $display("FAIL reset1 got p=%h d=%b b=%b a=%h b=%h want all 0", product1, done1, busy1, mult_a1, mult_b1);
    end
  endtask

  task automatic test_sequence();
    logic [7:0] want [4] = '{8'h5C, 8'hAC, 8'h53, 8'hA3};
    start = 1'b1;
    dataa = 8'hA5;
    datab = 8'h3C;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if ({mult_a0, mult_b0, done0, busy0} !== {want[k], 2'b01}) begin
        fails++;
        $display("FAIL seq_k%0d got a=%h b=%h done=%b busy=%b want %h done=0 busy=1", k, mult_a0, mult_b0, done0, busy0, want[k]);
      end
      tick();
    end
    tests++;
    if (!done0 || product0 !== 16'h26AC) begin
      fails++;
      $display("FAIL seq_done got done=%b p=%h want 1 26ac", done0, product0);
    end
    tick();
    tests++;
    if (done0 || product0 !== 16'h26AC || mult_a0 !== 4'd0 || mult_b0 !== 4'd0) begin
      fails++;
      $display("FAIL seq_after got done=%b p=%h a=%h b=%h want 0 26ac 0 0", done0, product0, mult_a0, mult_b0);
    end
    idle(4);
  endtask

  task automatic test_corners();
    logic [7:0] va [4] = '{8'hFF, 8'h00, 8'h01, 8'h12};
    logic [7:0] vb [4] = '{8'hFF, 8'h7E, 8'h80, 8'h34};
    logic [15:0] vp [4] = '{16'hFE01, 16'h0000, 16'h0080, 16'h03A8};
    int l0, l1;
    logic [15:0] p0, p1;
    for (int i = 0; i < 4; i++) begin
      op(va[i], vb[i], l0, l1, p0, p1);
      tests++;
      if (l0 != 5 || p0 !== vp[i]) begin
        fails++;
        $display("FAIL corner%0d_pp0 got lat=%0d p=%h want 5 %h", i, l0, p0, vp[i]);
      end
      tests++;
      if (l1 != 6 || p1 !== vp[i]) begin
        fails++;
        $display("FAIL corner%0d_pp1 got lat=%0d p=%h want 6 %h", i, l1, p1, vp[i]);
      end
    end
  endtask

  task automatic test_busy_start();
    int ndone = 0;
    int at = -1;
    logic [15:0] p = 'x;
    start = 1'b1;
    dataa = 8'h12;
    datab = 8'h34;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin start = 1'b1; dataa = 8'hFF; datab = 8'hFF; end
      if (c == 3) start = 1'b0;
      if (done0) begin ndone++; at = c; p = product0; end
      if (c == 7) begin
        tests++;
        if (busy0) begin
          fails++;
          $display("FAIL busy_nostart got busy=%b want 0", busy0);
        end
      end
      tick();
    end
    tests++;
    if (ndone != 1 || at != 5 || p !== 16'h03A8) begin
      fails++;
      $display("FAIL busy_start got n=%0d at=%0d p=%h want 1 5 03a8", ndone, at, p);
    end
  endtask

  task automatic test_reset_midcalc();
    int ndone = 0;
    int l0, l1;
    logic [15:0] p0, p1;
    start = 1'b1;
    dataa = 8'h12;
    datab = 8'h34;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (busy0 || done0 || product0 !== 16'd0) begin
      fails++;
      $display("FAIL rst_mid got busy=%b done=%b p=%h want 0 0 0", busy0, done0, product0);
    end
    for (int c = 0; c < 8; c++) begin
      if (done0 || done1) ndone++;
      tick();
    end
    tests++;
    if (ndone != 0) begin
      fails++;
      $display("FAIL rst_nodone got %0d pulses want 0", ndone);
    end
    op(8'h03, 8'h05, l0, l1, p0, p1);
    tests++;
    if (l0 != 5 || p0 !== 16'h000F || p1 !== 16'h000F) begin
      fails++;
      $display("FAIL rst_fresh got lat=%0d p0=%h p1=%h want 5 000f 000f", l0, p0, p1);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    start = 1'b1;
    dataa = 8'h10;
    datab = 8'h10;
    tick();
    dataa = 8'h20;
    datab = 8'h02;
    for (int c = 1; c <= 12; c++) begin
      if (done0 !== (c == 5 || c == 11)) bad++;
      if (c == 5 && product0 !== 16'h0100) bad++;
      if (c > 5 && c < 11 && product0 !== 16'h0100) bad++;
      if (c >= 11 && product0 !== 16'h0040) bad++;
      tick();
    end
    start = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL back_to_back got %0d bad cycles want 0 (p=%h)", bad, product0);
    end
    idle(10);
  endtask

  task automatic test_reg_pp();
    start = 1'b1;
    dataa = 8'hA5;
    datab = 8'h3C;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tests++;
      if (done1 || !busy1) begin
        fails++;
        $display("FAIL regpp_c%0d got done=%b busy=%b want 0 1", c, done1, busy1);
      end
      if (c == 5) begin
        tests++;
        if (mult_a1 !== 4'd0 || mult_b1 !== 4'd0) begin
          fails++;
          $display("FAIL regpp_last got a=%h b=%h want 0 0", mult_a1, mult_b1);
        end
      end
      tick();
    end
    tests++;
    if (!done1 || product1 !== 16'h26AC) begin
      fails++;
      $display("FAIL regpp_done got done=%b p=%h want 1 26ac", done1, product1);
    end
    idle(3);
  endtask

  task automatic test_random();
    int bad = 0;
    int l0, l1;
    logic [15:0] p0, p1;
    logic [7:0] a, b;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      op(a, b, l0, l1, p0, p1);
      tests++;
      if (l0 != 5 || l1 != 6 || p0 !== 16'(a) * 16'(b) || p1 !== 16'(a) * 16'(b)) begin
        fails++;
        if (bad++ < 5) $display("FAIL random %h*%h got p0=%h p1=%h lat=%0d/%0d want %h 5/6", a, b, p0, p1, l0, l1, 16'(a) * 16'(b));
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    dataa = '0;
    datab = '0;
    test_reset();
    test_sequence();
    test_corners();
    test_busy_start();
    test_reset_midcalc();
    test_back_to_back();
    test_reg_pp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
